// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller:
// func3 access encodings, opcode constants, FSM state type, XLEN.
package dmem_access_ctrl_pkg;

  localparam int unsigned XLEN_C = 64;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  // Access size from func3; the undefined encoding 111 behaves as a doubleword.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W, F3_WU: return SZ_W;
      default:     return SZ_D;
    endcase
  endfunction

  // Zero-extending loads; D needs no extension at full width.
  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU) || (f3 == F3_WU);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load data aligner: picks the accessed bytes out of a returned doubleword
// and sign- or zero-extends them to XLEN. Purely combinational.
module dmem_load_align
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_C
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;
  logic            sext;

  // Shift the addressed byte down to lane 0, then extend per access width.
  always_comb begin
    shifted  = rdata_i >> {off_i, 3'b000};
    sext     = ~f3_unsigned(func3_i);
    result_o = shifted;
    case (f3_size(func3_i))
      SZ_B:    result_o = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
      SZ_H:    result_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
      SZ_W:    result_o = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one load/store at a time, valid/ready
// request to a 64-bit byte-lane memory, aligned/extended writeback.
// Build option: MISALIGN_TRAP_EN -- misaligned accesses complete with
// fault instead of being force-aligned to the access size.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = XLEN_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_read_en,
  input  logic              lsu_write_en,
  input  logic [2:0]        lsu_func3,
  input  logic [ADDR_W-1:0] lsu_address,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [4:0]        lsu_rd_idx,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [7:0]        mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd_idx,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, acc_addr;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic              load_q, load_d;
  logic [2:0]        off;
  logic [7:0]        strb;
  logic [XLEN-1:0]   load_result;
`ifdef MISALIGN_TRAP_EN
  logic              fault_q, fault_d, misalign;
`endif

  // Address captured at accept: checked for misalignment, or force-aligned.
  always_comb begin
    acc_addr = lsu_address;
`ifdef MISALIGN_TRAP_EN
    misalign = 1'b0;
    case (f3_size(lsu_func3))
      SZ_H:    misalign = lsu_address[0];
      SZ_W:    misalign = |lsu_address[1:0];
      SZ_D:    misalign = |lsu_address[2:0];
      default: misalign = 1'b0;
    endcase
`else
    case (f3_size(lsu_func3))
      SZ_H:    acc_addr[0]   = 1'b0;
      SZ_W:    acc_addr[1:0] = '0;
      SZ_D:    acc_addr[2:0] = '0;
      default: acc_addr      = lsu_address;
    endcase
`endif
  end

  // State and captured-operation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      func3_q   <= '0;
      wdata_q   <= '0;
      wb_data_q <= '0;
      rd_idx_q  <= '0;
      load_q    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      func3_q   <= func3_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      rd_idx_q  <= rd_idx_d;
      load_q    <= load_d;
`ifdef MISALIGN_TRAP_EN
      fault_q   <= fault_d;
`endif
    end
  end

  // Next-state logic: accept, request handshake, response wait, completion.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    func3_d   = func3_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    rd_idx_d  = rd_idx_q;
    load_d    = load_q;
`ifdef MISALIGN_TRAP_EN
    fault_d   = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (lsu_valid && (lsu_read_en || lsu_write_en)) begin
          addr_d    = acc_addr;
          func3_d   = lsu_func3;
          wdata_d   = lsu_wdata;
          rd_idx_d  = lsu_rd_idx;
          load_d    = lsu_read_en;
          wb_data_d = '0;
`ifdef MISALIGN_TRAP_EN
          fault_d   = misalign;
          state_d   = misalign ? S_DONE : S_REQ;
`else
          state_d   = S_REQ;
`endif
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = load_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_data_d = load_result;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign off = addr_q[2:0];

  // Byte-enable pattern for the captured access.
  always_comb begin
    case (f3_size(func3_q))
      SZ_B:    strb = 8'h01 << off;
      SZ_H:    strb = 8'h03 << off;
      SZ_W:    strb = 8'h0F << off;
      default: strb = 8'hFF;
    endcase
  end

  dmem_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i (mem_rdata),
    .off_i   (off),
    .func3_i (func3_q),
    .result_o(load_result)
  );

  // Request fields are zero outside REQ so idle/reset values read as 0.
  assign lsu_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_we        = mem_req_valid & ~load_q;
  assign mem_addr      = mem_req_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_wdata     = mem_req_valid ? (wdata_q << {off, 3'b000}) : '0;
  assign mem_wstrb     = mem_req_valid ? strb : '0;
  assign wb_valid      = (state_q == S_DONE);
  assign wb_rd_idx     = rd_idx_q;
  assign wb_data       = wb_data_q;
`ifdef MISALIGN_TRAP_EN
  assign wb_we         = wb_valid & load_q & ~fault_q;
  assign fault         = wb_valid & fault_q;
`else
  assign wb_we         = wb_valid & load_q;
  assign fault         = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: byte-array reference model,
// behavioural memory responder, writeback monitor.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, lsu_read_en, lsu_write_en;
  logic [2:0]  lsu_func3;
  logic [31:0] lsu_address;
  logic [63:0] lsu_wdata;
  logic [4:0]  lsu_rd_idx;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        wb_valid, wb_we, fault;
  logic [4:0]  wb_rd_idx;
  logic [63:0] wb_data;

  dmem_access_ctrl #(.ADDR_W(32), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_read_en(lsu_read_en), .lsu_write_en(lsu_write_en),
    .lsu_func3(lsu_func3), .lsu_address(lsu_address),
    .lsu_wdata(lsu_wdata), .lsu_rd_idx(lsu_rd_idx),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic        we;
    logic        is_load;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        fault;
    int          offer;
    int          lat_exact;
    int          lat_min;
  } wb_t;

  req_t exp_req[$];
  wb_t  exp_wb[$];
  logic [63:0] mem_img [logic [31:0]];
  int n_checks = 0;
  int n_fail   = 0;
  int force_ready_delay = -1;
  int force_rsp_delay   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return {a * 32'h9E3779B1, a ^ 32'hDEADBEEF};
  endfunction

  // Offer one operation; expectations come from a byte-level model of the access.
  task automatic do_op(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [4:0] rd, input int lat_exact);
    int n, off, eff, guard;
    logic sgn, trap;
    logic [63:0] line, val;
    req_t r;
    wb_t  w;
    guard = 0;
    while (!lsu_ready && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin chk("lsu_ready_wait", lsu_ready, 1); return; end
    case (f3[1:0])
      2'd0: n = 1;
      2'd1: n = 2;
      2'd2: n = 4;
      default: n = 8;
    endcase
    sgn  = (f3[2] == 1'b0) && (f3[1:0] != 2'd3);
    off  = int'(addr[2:0]);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (off % n) != 0;
    eff  = off;
`else
    eff  = off - (off % n);
`endif
    val  = '0;
    line = mem_rd({addr[31:3], 3'b000});
    r.addr = {addr[31:3], 3'b000};
    r.we = !re;
    r.strb = '0;
    r.wdata = '0;
    if (!trap) begin
      for (int i = 0; i < n; i++) begin
        val[8*i +: 8] = line[8*(eff+i) +: 8];
        r.strb[eff+i] = 1'b1;
      end
      if (sgn && val[8*n-1]) for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
      for (int j = eff; j < 8; j++) r.wdata[8*j +: 8] = wd[8*(j-eff) +: 8];
    end
    w.we = re && !trap;
    w.is_load = re;
    w.rd = rd;
    w.data = (re && !trap) ? val : 64'd0;
    w.fault = trap;
    w.offer = cyc;
    w.lat_exact = lat_exact;
    w.lat_min = trap ? 1 : (re ? 3 : 2);
    lsu_valid = 1'b1; lsu_read_en = re; lsu_write_en = we;
    lsu_func3 = f3; lsu_address = addr; lsu_wdata = wd; lsu_rd_idx = rd;
    if (re || we) begin
      if (!trap) exp_req.push_back(r);
      exp_wb.push_back(w);
    end
    @(negedge clk);
    lsu_valid = 1'b0; lsu_read_en = 1'b0; lsu_write_en = 1'b0;
    lsu_address = $urandom; lsu_wdata = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_wb.size() != 0 || !lsu_ready) && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("drain_timeout", 64'(exp_wb.size()), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lsu_ready"}, lsu_ready, 1);
    chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rd_idx"}, wb_rd_idx, 0);
    chk({tag, "_fault"}, fault, 0);
  endtask

  // Memory responder: random ready stalls, delayed read responses,
  // request fields compared against the model on every REQ cycle.
  initial begin
    int stall = -1;
    bit pend = 1'b0;
    int pcnt = 0;
    logic [63:0] pdata = '0;
    req_t r;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (pend) begin
        if (pcnt == 0) begin mem_rsp_valid = 1'b1; mem_rdata = pdata; pend = 1'b0; end
        else pcnt--;
      end
      if (mem_req_valid) begin
        chk("lsu_ready_in_req", lsu_ready, 0);
        if (exp_req.size() == 0) begin
          chk("unexpected_req", mem_req_valid, 0);
          mem_req_ready = 1'b1;
          if (!mem_we) begin pend = 1'b1; pcnt = 0; pdata = mem_rd(mem_addr); end
        end else begin
          r = exp_req[0];
          if (stall < 0) stall = (force_ready_delay >= 0) ? force_ready_delay : int'($urandom_range(0, 3));
          chk("req_addr", mem_addr, r.addr);
          chk("req_we", mem_we, r.we);
          chk("req_strb", mem_wstrb, r.strb);
          if (r.we) chk("req_wdata", mem_wdata, r.wdata);
          if (stall > 0) begin
            mem_req_ready = 1'b0;
            stall--;
          end else begin
            mem_req_ready = 1'b1;
            stall = -1;
            void'(exp_req.pop_front());
            if (!mem_we) begin
              pend = 1'b1;
              pcnt = (force_rsp_delay >= 0) ? force_rsp_delay : int'($urandom_range(0, 3));
              pdata = mem_rd(mem_addr);
            end
          end
        end
      end else begin
        stall = -1;
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Writeback monitor: pops the scoreboard on every wb_valid.
  initial begin
    bit prev = 1'b0;
    wb_t w;
    int lat;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        chk("wb_single_pulse", 64'(prev), 0);
        chk("lsu_ready_in_done", lsu_ready, 0);
        if (exp_wb.size() == 0) chk("unexpected_wb", wb_valid, 0);
        else begin
          w = exp_wb.pop_front();
          chk("wb_we", wb_we, w.we);
          chk("wb_fault", fault, w.fault);
          chk("wb_data", wb_data, w.data);
          if (w.is_load) chk("wb_rd_idx", wb_rd_idx, w.rd);
          lat = cyc - w.offer;
          if (w.lat_exact > 0) chk("wb_latency", 64'(lat), 64'(w.lat_exact));
          else chk("wb_latency_min", 64'(lat >= w.lat_min), 1);
        end
      end
      prev = wb_valid;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb_cnt, rsp_seen, sel;
    rst_n = 1'b0;
    lsu_valid = 1'b0; lsu_read_en = 1'b0; lsu_write_en = 1'b0;
    lsu_func3 = '0; lsu_address = '0; lsu_wdata = '0; lsu_rd_idx = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // SB, immediate ready: lane 5 strobe, 2-cycle completion.
    force_ready_delay = 0;
    do_op(1'b0, 1'b1, 3'b000, 32'h1005, 64'hAB, 5'd3, 2);
    wait_idle();
    // LB sign extension, LWU upper word, both at minimum latency.
    force_rsp_delay = 0;
    mem_img[32'h2000] = 64'h00000000_80000000;
    mem_img[32'h2800] = 64'h89ABCDEF_80000000;
    do_op(1'b1, 1'b0, 3'b000, 32'h2003, 64'h0, 5'd7, 3);
    wait_idle();
    do_op(1'b1, 1'b0, 3'b110, 32'h2804, 64'h0, 5'd11, 0);
    wait_idle();
    // SD with a 4-cycle ready stall.
    force_ready_delay = 4;
    do_op(1'b0, 1'b1, 3'b011, 32'h4000, 64'h01234567_89ABCDEF, 5'd0, 0);
    wait_idle();
    force_ready_delay = -1;
    force_rsp_delay = -1;
    // Misaligned LH, nop offer, both enables, illegal func3 load/store.
    mem_img[32'h3000] = 64'h11223344_55668001;
    do_op(1'b1, 1'b0, 3'b001, 32'h3001, 64'h0, 5'd9, 0);
    wait_idle();
    do_op(1'b0, 1'b0, 3'b010, 32'h5000, 64'h55, 5'd4, 0);
    wait_idle();
    do_op(1'b1, 1'b1, 3'b010, 32'h5008, 64'hFFFF_0000, 5'd12, 0);
    do_op(1'b1, 1'b0, 3'b111, 32'h6000, 64'h0, 5'd13, 0);
    do_op(1'b0, 1'b1, 3'b111, 32'h6003, 64'hCAFEF00D_12345678, 5'd14, 0);
    wait_idle();

    for (int k = 0; k < 200; k++) begin
      sel = int'($urandom_range(0, 9));
      do_op(sel == 1 || (sel >= 2 && sel <= 5), sel == 1 || sel >= 6,
            3'($urandom_range(0, 7)), $urandom_range(0, 32'h7FFF),
            {$urandom, $urandom}, 5'($urandom_range(0, 31)), 0);
    end
    wait_idle();

    // Reset while a load waits for its response; the late response is dropped.
    force_ready_delay = 0;
    force_rsp_delay = 4;
    do_op(1'b1, 1'b0, 3'b011, 32'h7000, 64'h0, 5'd1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    exp_wb.delete();
    exp_req.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wb_cnt = 0;
    rsp_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (wb_valid) wb_cnt++;
      if (mem_rsp_valid) rsp_seen = 1;
    end
    chk("no_wb_after_reset", 64'(wb_cnt), 0);
    chk("late_rsp_delivered", 64'(rsp_seen), 1);
    chk("idle_after_reset", lsu_ready, 1);
    force_ready_delay = -1;
    force_rsp_delay = -1;
    @(negedge clk);

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 1));
      do_op(sel == 0, sel == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 32'h7FFF),
            {$urandom, $urandom}, 5'($urandom_range(0, 31)), 0);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Downstream neighbour of the load/store address unit in the RV64 pipeline. It accepts one memory operation at a time: address, read/write enable, func3 width and store data. It drives a byte-addressed 64-bit data-memory port with a valid/ready request and a response-valid read path. For loads it aligns and sign- or zero-extends the returned doubleword, then hands the result and destination index to writeback.

Parameters:
ADDR_W, 32, byte address width, matching the load/store unit address output
XLEN, 64, data width of the register file and memory port

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
lsu_valid  in  1  operation offered by the load/store unit
lsu_ready  out  1  block can accept an operation
lsu_read_en  in  1  load
lsu_write_en  in  1  store; both enables high is illegal and treated as a load
lsu_func3  in  3  000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
lsu_address  in  ADDR_W  byte address
lsu_wdata  in  XLEN  store data, right-justified
lsu_rd_idx  in  5  load destination register
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  doubleword-aligned address, bits [2:0] = 0
mem_wdata  out  XLEN  store data shifted into byte lanes
mem_wstrb  out  8  byte enables
mem_rsp_valid  in  1  read data valid (ignored for writes)
mem_rdata  in  XLEN  read doubleword
wb_valid  out  1  one-cycle completion pulse (loads and stores)
wb_we  out  1  register write required (loads only)
wb_rd_idx  out  5  destination index
wb_data  out  XLEN  extended load result, 0 for stores
fault  out  1  misaligned access, valid with wb_valid (feature only)

Behaviour:
- Reset values:
  - state = IDLE; lsu_ready = 1.
  - mem_req_valid, mem_we, wb_valid, wb_we and fault = 0.
  - mem_addr, mem_wdata, mem_wstrb, wb_data and wb_rd_idx = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - lsu_ready = 1.
  - On lsu_valid & (read_en | write_en), register address, func3, wdata and rd_idx, then go to REQ.
  - lsu_valid with both enables low is consumed and ignored, with no wb_valid.
- REQ:
  - mem_req_valid = 1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable until mem_req_ready.
  - On handshake: a store goes to DONE, a load goes to WAIT.
- WAIT:
  - Wait for mem_rsp_valid, with no timeout. Latch the extended data and go to DONE.
  - A response arriving in the same cycle as the request handshake is not allowed; the memory responds at least one cycle later.
- DONE:
  - wb_valid = 1 for exactly one cycle, then return to IDLE.
  - lsu_ready is 0 in REQ, WAIT and DONE, so there is no back-to-back acceptance.
- Minimum latency from accept to wb_valid: store 2 cycles; load 3 cycles.
- Byte lanes use off = addr[2:0]:
  - Strobe is B = 1<<off, H = 3<<off, W = 15<<off, D = 8'hFF.
  - mem_wdata = wdata << (8*off).
  - Load result = (rdata >> 8*off), truncated to the access width, then sign-extended for B/H/W and zero-extended for BU/HU/WU/D.
- An illegal func3 (111) is treated as D.
- mem_we for a load is 0 and its strobe is still driven (ignored by memory).
- Reset asserted mid-operation aborts immediately to IDLE and drops mem_req_valid. An outstanding memory response arriving after reset is ignored.

Optional Feature:
MISALIGN_TRAP_EN. Misaligned means H with off[0]≠0, W with off[1:0]≠0, or D with off≠0.
- Defined: a misaligned access skips REQ/WAIT and goes straight to DONE with fault = 1, wb_we = 0 and wb_data = 0. No memory request is issued.
- Undefined: the fault port is tied 0. The address is force-aligned to the access size by clearing the low bits, and the access proceeds normally.

Decomposition:
- Shared package holds:
  - func3 width/sign encodings
  - opcode constants for LOAD (0000011) and STORE (0100011)
  - the state enum
  - an XLEN constant
- One natural sub-module: dmem_load_align, purely combinational. It takes rdata, off and func3 and produces the extended result; it is reused by any future cache path.

Test Plan:
- SB, address 0x1005, wdata 0xAB, ready on first cycle -> mem_addr 0x1000, wstrb 0x20, wdata lane 5 = 0xAB; wb_valid 2 cycles after accept, wb_we 0.
- LB, address 0x2003, rdata 0x00000000_80000000_... with byte 3 = 0x80 -> wb_data 0xFFFFFFFFFFFFFF80, wb_we 1, rd_idx echoed.
- LWU, address 0x2004, rdata upper word 0x89ABCDEF -> wb_data 0x0000000089ABCDEF.
- SD with mem_req_ready low for 4 cycles -> request fields stable all 4 cycles, lsu_ready 0 throughout, single wb_valid pulse.
- LH at address 0x3001 -> with the macro: fault 1, no mem_req_valid. Without the macro: mem_addr 0x3000 and the halfword is taken from off 0.
- Load in WAIT, rst_n pulsed low -> all outputs at reset values asynchronously; a later mem_rsp_valid produces no wb_valid.
